// File: rtl/rv32_pkg.sv
// Shared rv32 core types and constants used across pipeline stages.
package rv32_pkg;

  localparam int unsigned ILEN = 32;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Fetch-to-decode payload: instruction word, its PC and an access-fault flag.
  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [ILEN-1:0] pc;
    logic            fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for fetch entries with flush, count and full/empty.
module fetch_fifo #(
  parameter type         entry_t = logic [0:0],
  parameter int unsigned DEPTH   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  entry_t                 data_i,
  input  logic                   pop_i,
  output entry_t                 data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               do_push;
  logic               do_pop;

  // Status flags and qualified push/pop; the head is read straight from storage.
  always_comb begin
    full_o  = (count_q == CNT_W'(DEPTH));
    empty_o = (count_q == '0);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    count_o = count_q;
    data_o  = mem_q[rd_ptr_q];
  end

  // Pointer, count and storage update; flush wins over push and pop.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: sequential PC generation, credit-limited memory
// requests, in-order response buffering and redirect flush for decode.
module fetch_stage
  import rv32_pkg::*;
#(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] RESET_PC   = DATA_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [DATA_W-1:0] imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [DATA_W-1:0] imem_rsp_data_i,
  input  logic              imem_rsp_err_i,
  input  logic              redirect_i,
  input  logic [DATA_W-1:0] redirect_pc_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [DATA_W-1:0] id_instr_o,
  output logic [DATA_W-1:0] id_pc_o,
  output logic              id_fault_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] resp_pc_q;
  logic [CNT_W-1:0]  outstanding_q;
  logic [CNT_W-1:0]  drop_q;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [SUM_W-1:0]  credit_used;
  logic              req_fire;
  logic              drop_rsp;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] redirect_pc_aligned;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

  // Request issue: buffered plus in-flight entries never exceed the FIFO size.
  always_comb begin
    credit_used         = {1'b0, fifo_count} + {1'b0, outstanding_q};
    imem_req_valid_o    = rst_ni && !redirect_i && (credit_used < SUM_W'(FIFO_DEPTH));
    imem_req_addr_o     = pc_q;
    req_fire            = imem_req_valid_o && imem_req_ready_i;
    redirect_pc_aligned = redirect_pc_i & ~DATA_W'(3);
  end

  // Response routing and decode handshake.
  always_comb begin
    drop_rsp         = imem_rsp_valid_i && (drop_q != '0);
    push             = imem_rsp_valid_i && !drop_rsp && !redirect_i;
    push_entry.instr = ILEN'(imem_rsp_data_i);
    push_entry.pc    = ILEN'(resp_pc_q);
    push_entry.fault = imem_rsp_err_i;
    id_valid_o       = !fifo_empty && !redirect_i;
    pop              = id_valid_o && id_ready_i;
    id_instr_o       = DATA_W'(head_entry.instr);
    id_pc_o          = DATA_W'(head_entry.pc);
    id_fault_o       = head_entry.fault;
  end

  // PC, response-PC and in-flight bookkeeping. outstanding_q counts every
  // request still owed a response, including ones already marked stale, so on
  // redirect it alone gives the number of responses left to discard.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      if (redirect_i) begin
        pc_q      <= redirect_pc_aligned;
        resp_pc_q <= redirect_pc_aligned;
        drop_q    <= outstanding_q - CNT_W'(imem_rsp_valid_i);
      end else begin
        if (req_fire) begin
          pc_q <= pc_q + DATA_W'(4);
        end
        if (push) begin
          resp_pc_q <= resp_pc_q + DATA_W'(4);
        end
        if (drop_rsp) begin
          drop_q <= drop_q - CNT_W'(1);
        end
      end
      outstanding_q <= outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid_i);
    end
  end

  fetch_fifo #(
    .entry_t (fetch_entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifndef SYNTHESIS
  // Credit rule guarantees space for every accepted response.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> !fifo_full);
  // Every response must match an accepted request.
  a_no_out_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    imem_rsp_valid_i |-> (outstanding_q != '0));
  // Stale responses are a subset of in-flight ones.
  a_drop_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
    drop_q <= outstanding_q);
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage with an in-order memory model and a
// PC-stream scoreboard.
module tb_fetch_stage;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [DW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [DW-1:0] imem_rsp_data;
  logic          imem_rsp_err;
  logic          redirect;
  logic [DW-1:0] redirect_pc;
  logic          id_valid;
  logic          id_ready;
  logic [DW-1:0] id_instr;
  logic [DW-1:0] id_pc;
  logic          id_fault;

  int checks   = 0;
  int failures = 0;

  fetch_stage #(
    .DATA_W     (32),
    .FIFO_DEPTH (4),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .imem_req_valid_o (imem_req_valid),
    .imem_req_ready_i (imem_req_ready),
    .imem_req_addr_o  (imem_req_addr),
    .imem_rsp_valid_i (imem_rsp_valid),
    .imem_rsp_data_i  (imem_rsp_data),
    .imem_rsp_err_i   (imem_rsp_err),
    .redirect_i       (redirect),
    .redirect_pc_i    (redirect_pc),
    .id_valid_o       (id_valid),
    .id_ready_i       (id_ready),
    .id_instr_o       (id_instr),
    .id_pc_o          (id_pc),
    .id_fault_o       (id_fault)
  );

  always #5 clk = ~clk;

  // In-order instruction memory: fixed latency, data = addr ^ 0xFFFF0000.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          cyc      = 0;
  int          mem_lat  = 1;
  logic        err_en   = 1'b0;
  logic [31:0] err_addr = 32'h0;

  always @(posedge clk) begin
    mreq_t h;
    cyc = cyc + 1;
    if (!rst_n) begin
      mq.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      h.addr = imem_req_addr;
      h.due  = cyc + mem_lat - 1;
      mq.push_back(h);
    end
    #1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      h              = mq.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = h.addr ^ 32'hFFFF_0000;
      imem_rsp_err   = err_en && (h.addr == err_addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      imem_rsp_err   = 1'b0;
    end
  end

  // Reference: the instruction fetched from pc.
  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return pc ^ 32'hFFFF_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Leaves rst_n freshly released: the current cycle is cycle 0.
  task automatic do_reset();
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b0;
    err_en         = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    mem_lat  = 1;
    id_ready = 1'b1;
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid);
    end
    checks++;
    if (id_valid !== 1'b0) begin
      failures++; $display("FAIL reset_id_valid got=%b exp=0", id_valid);
    end
    checks++;
    if (id_instr !== 32'h0) begin
      failures++; $display("FAIL reset_id_instr got=%h exp=0", id_instr);
    end
    checks++;
    if (id_pc !== 32'h0) begin
      failures++; $display("FAIL reset_id_pc got=%h exp=0", id_pc);
    end
    checks++;
    if (id_fault !== 1'b0) begin
      failures++; $display("FAIL reset_id_fault got=%b exp=0", id_fault);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    mem_lat  = 1;
    id_ready = 1'b1;
    exp_pc   = 32'h0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (k == 0) begin
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
          failures++;
          $display("FAIL stream_first_req got=%b/%h exp=1/00000000", imem_req_valid, imem_req_addr);
        end
      end
      checks++;
      if (id_valid !== (k >= 2)) begin
        failures++; $display("FAIL stream_valid cycle=%0d got=%b exp=%b", k, id_valid, (k >= 2));
      end
      if (id_valid && id_ready) begin
        checks++;
        if (id_pc !== exp_pc || id_instr !== exp_instr(exp_pc) || id_fault !== 1'b0) begin
          failures++;
          $display("FAIL stream_entry got=%h/%h/%b exp=%h/%h/0", id_pc, id_instr, id_fault, exp_pc, exp_instr(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    int nreq;
    int ndel;
    do_reset();
    mem_lat  = 1;
    id_ready = 1'b0;
    nreq     = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (imem_req_valid && imem_req_ready) nreq++;
      tick();
    end
    #1;
    checks++;
    if (nreq != 4) begin
      failures++; $display("FAIL bp_requests got=%0d exp=4", nreq);
    end
    checks++;
    if (imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL bp_req_valid got=%b exp=0", imem_req_valid);
    end
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
      failures++; $display("FAIL bp_head got=%b/%h exp=1/00000000", id_valid, id_pc);
    end
    exp_pc = 32'h0;
    ndel   = 0;
    for (int k = 0; k < 40; k++) begin
      id_ready       = 1'($urandom_range(0, 1));
      imem_req_ready = 1'($urandom_range(0, 1));
      #1;
      if (id_valid && id_ready) begin
        checks++;
        if (id_pc !== exp_pc || id_instr !== exp_instr(exp_pc)) begin
          failures++; $display("FAIL bp_drain got=%h/%h exp=%h/%h", id_pc, id_instr, exp_pc, exp_instr(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        ndel++;
      end
      tick();
    end
    imem_req_ready = 1'b1;
    checks++;
    if (ndel < 6) begin
      failures++; $display("FAIL bp_drain_count got=%0d exp>=6", ndel);
    end
  endtask

  task automatic test_redirect_drop();
    logic [31:0] exp_pc;
    int nreq;
    int ndel;
    do_reset();
    mem_lat  = 3;
    id_ready = 1'b1;
    nreq     = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      if (imem_req_valid && imem_req_ready) nreq++;
      tick();
    end
    redirect    = 1'b1;
    redirect_pc = 32'h0000_1003;
    #1;
    checks++;
    if (nreq != 2 || imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
      failures++;
      $display("FAIL rd_cycle got=%0d/%b/%b exp=2/0/0", nreq, imem_req_valid, id_valid);
    end
    tick();
    redirect = 1'b0;
    exp_pc   = 32'h0000_1000;
    ndel     = 0;
    for (int k = 0; k < 30; k++) begin
      id_ready = 1'($urandom_range(0, 1));
      #1;
      if (id_valid && id_ready) begin
        checks++;
        if (id_pc !== exp_pc || id_instr !== exp_instr(exp_pc)) begin
          failures++; $display("FAIL rd_entry got=%h/%h exp=%h/%h", id_pc, id_instr, exp_pc, exp_instr(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        ndel++;
      end
      tick();
    end
    checks++;
    if (ndel < 4) begin
      failures++; $display("FAIL rd_count got=%0d exp>=4", ndel);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    int ndel;
    do_reset();
    mem_lat  = 2;
    id_ready = 1'b0;
    repeat (3) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    #1;
    checks++;
    if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_first got=%b/%b exp=0/0", id_valid, imem_req_valid);
    end
    tick();
    redirect_pc = 32'h0000_0300;
    #1;
    checks++;
    if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_second got=%b/%b exp=0/0", id_valid, imem_req_valid);
    end
    tick();
    redirect = 1'b0;
    exp_pc   = 32'h0000_0300;
    ndel     = 0;
    for (int k = 0; k < 30; k++) begin
      id_ready       = 1'($urandom_range(0, 1));
      imem_req_ready = 1'($urandom_range(0, 1));
      #1;
      if (id_valid && id_ready) begin
        checks++;
        if (id_pc !== exp_pc || id_instr !== exp_instr(exp_pc)) begin
          failures++; $display("FAIL b2b_entry got=%h/%h exp=%h/%h", id_pc, id_instr, exp_pc, exp_instr(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        ndel++;
      end
      tick();
    end
    imem_req_ready = 1'b1;
    checks++;
    if (ndel < 4) begin
      failures++; $display("FAIL b2b_count got=%0d exp>=4", ndel);
    end
  endtask

  task automatic test_fault();
    logic [31:0] exp_pc;
    int nfault;
    do_reset();
    mem_lat  = 1;
    err_en   = 1'b1;
    err_addr = 32'h0000_0008;
    exp_pc   = 32'h0;
    nfault   = 0;
    for (int k = 0; k < 24; k++) begin
      id_ready = 1'($urandom_range(0, 1));
      #1;
      if (id_valid && id_ready) begin
        checks++;
        if (id_pc !== exp_pc || id_instr !== exp_instr(exp_pc) || id_fault !== (exp_pc == 32'h8)) begin
          failures++;
          $display("FAIL fault_entry got=%h/%h/%b exp=%h/%h/%b", id_pc, id_instr, id_fault, exp_pc, exp_instr(exp_pc), (exp_pc == 32'h8));
        end
        if (id_fault) nfault++;
        exp_pc = exp_pc + 32'd4;
      end
      tick();
    end
    err_en = 1'b0;
    checks++;
    if (nfault != 1 || exp_pc <= 32'h8) begin
      failures++; $display("FAIL fault_count got=%0d next_pc=%h exp=1 past 00000008", nfault, exp_pc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    logic [31:0] got [3];
    int ndel;
    do_reset();
    mem_lat  = 1;
    id_ready = 1'b1;
    repeat (3) tick();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFB;
    tick();
    redirect = 1'b0;
    exp_pc   = 32'hFFFF_FFF8;
    ndel     = 0;
    got      = '{default: 32'hDEAD_BEEF};
    for (int k = 0; k < 12; k++) begin
      #1;
      if (id_valid && id_ready) begin
        checks++;
        if (id_pc !== exp_pc || id_instr !== exp_instr(exp_pc)) begin
          failures++; $display("FAIL wrap_entry got=%h/%h exp=%h/%h", id_pc, id_instr, exp_pc, exp_instr(exp_pc));
        end
        if (ndel < 3) got[ndel] = id_pc;
        exp_pc = exp_pc + 32'd4;
        ndel++;
      end
      tick();
    end
    checks++;
    if (got[0] !== 32'hFFFF_FFF8 || got[1] !== 32'hFFFF_FFFC || got[2] !== 32'h0000_0000) begin
      failures++;
      $display("FAIL wrap_seq got=%h,%h,%h exp=fffffff8,fffffffc,00000000", got[0], got[1], got[2]);
    end
  endtask

  task automatic test_random(input int lat);
    logic [31:0] exp_pc;
    int ndel;
    do_reset();
    mem_lat = lat;
    exp_pc  = 32'h0;
    ndel    = 0;
    for (int k = 0; k < 300; k++) begin
      id_ready       = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      redirect       = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      #1;
      if (redirect) begin
        checks++;
        if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
          failures++; $display("FAIL rand_redirect got=%b/%b exp=0/0", id_valid, imem_req_valid);
        end
        exp_pc = redirect_pc & ~32'h3;
      end else if (id_valid && id_ready) begin
        checks++;
        if (id_pc !== exp_pc || id_instr !== exp_instr(exp_pc) || id_fault !== 1'b0) begin
          failures++;
          $display("FAIL rand_entry lat=%0d got=%h/%h/%b exp=%h/%h/0", lat, id_pc, id_instr, id_fault, exp_pc, exp_instr(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        ndel++;
      end
      tick();
    end
    redirect       = 1'b0;
    imem_req_ready = 1'b1;
    checks++;
    if (ndel < 20) begin
      failures++; $display("FAIL rand_count lat=%0d got=%0d exp>=20", lat, ndel);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_rsp_err   = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_back_to_back();
    test_fault();
    test_wrap();
    test_random(1);
    test_random(2);
    test_random(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
